fpu_issue_arbiter: RTL and testbench

- Shares one pipelined single-precision FPU add/sub datapath among N requesters.
- Arbitrates issue round-robin and drives the FPU operand and operation inputs.
- Tracks every in-flight operation with a valid/ID/tag shift register matched to the fixed FPU latency.
- Returns each result to its originating requester with its tag. The FPU has no stall, so responses cannot be back-pressured.

---
 rtl/fpu_arb_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/fpu_issue_arbiter.sv | 113 +++++++++++
 tb/tb_fpu_issue_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared constants, tracking-entry type and width helper for the FPU issue arbiter.
package fpu_arb_pkg;

  // Default operand width and FPU pipeline depth (input regs plus five stages).
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned FPU_LATENCY = 6;

  // Tracking entries carry the widest id/tag the arbiter supports (8 requesters,
  // 8-bit tags); narrower instances zero-extend on entry and truncate on exit.
  localparam int unsigned TRACK_ID_W  = 3;
  localparam int unsigned TRACK_TAG_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [TRACK_ID_W-1:0]  id;
    logic [TRACK_TAG_W-1:0] tag;
  } track_entry_t;

  // Ceiling log2 with a floor of 1 so single-bit fields never collapse to zero width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the slot after the last grant and remembers
// the winner only when the caller reports that the grant was consumed.
module rr_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned ID_W = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic [ID_W-1:0] last_q;
  logic            found;
  int unsigned     idx;

  // Pick the first requester at or after last_grant+1, wrapping modulo N.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

  // Pointer starts at N-1 so requester 0 has priority after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= ID_W'(N - 1);
    end else if (advance) begin
      last_q <= grant_id;
    end
  end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Shares one fixed-latency FPU add/sub pipeline among N_REQ requesters. Issue is
// round-robin; a {valid,id,tag} shift register matched to the FPU latency routes
// each result back to its requester. Responses cannot be stalled.
module fpu_issue_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned FPU_LATENCY = fpu_arb_pkg::FPU_LATENCY,
  parameter int unsigned DATA_W      = fpu_arb_pkg::DATA_W,
  localparam int unsigned ID_W       = fpu_arb_pkg::clog2(N_REQ),
  localparam int unsigned CNT_W      = fpu_arb_pkg::clog2(FPU_LATENCY + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    issue_en,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_op1,
  input  logic [N_REQ*DATA_W-1:0] req_op2,
  input  logic [N_REQ-1:0]        req_operation,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0]       fpu_operand1,
  output logic [DATA_W-1:0]       fpu_operand2,
  output logic                    fpu_operation,
  input  logic [DATA_W-1:0]       fpu_result,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic [DATA_W-1:0]       rsp_result,
  output logic [CNT_W-1:0]        inflight,
  output logic                    busy
);

  import fpu_arb_pkg::*;

  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             xfer;
  logic [TAG_W-1:0] tag_sel;
  track_entry_t     head;
  track_entry_t     pipe_q [FPU_LATENCY];
  logic [CNT_W-1:0] inflight_q;

  // Reset and issue_en mask requests before arbitration so no grant can leak out.
  assign arb_req = req_valid & {N_REQ{issue_en & ~RST}};

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .clk      (CLK),
    .rst      (RST),
    .req      (arb_req),
    .advance  (xfer),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // A grant is only ever given to a valid requester, so any grant is a transfer.
  assign xfer      = |grant;
  assign req_ready = grant;

  // Steer the granted requester onto the FPU inputs; idle cycles feed 0.0 + 0.0.
  always_comb begin
    fpu_operand1  = '0;
    fpu_operand2  = '0;
    fpu_operation = 1'b0;
    tag_sel       = '0;
    if (xfer) begin
      fpu_operand1  = req_op1[grant_id * DATA_W +: DATA_W];
      fpu_operand2  = req_op2[grant_id * DATA_W +: DATA_W];
      fpu_operation = req_operation[grant_id];
      tag_sel       = req_tag[grant_id * TAG_W +: TAG_W];
    end
  end

  // Build the tracking entry that enters the pipe alongside the FPU operands.
  always_comb begin
    head       = '0;
    head.valid = xfer;
    head.id    = TRACK_ID_W'(grant_id);
    head.tag   = TRACK_TAG_W'(tag_sel);
  end

  // Tracking pipe shifts every cycle in lockstep with the FPU stages.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < FPU_LATENCY; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= head;
      for (int k = 1; k < FPU_LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign rsp_valid  = pipe_q[FPU_LATENCY-1].valid;
  assign rsp_id     = ID_W'(pipe_q[FPU_LATENCY-1].id);
  assign rsp_tag    = TAG_W'(pipe_q[FPU_LATENCY-1].tag);
  assign rsp_result = fpu_result;

  // Count in-flight ops; simultaneous issue and retire cancel out.
  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight_q <= '0;
    end else if (xfer && !rsp_valid) begin
      inflight_q <= inflight_q + CNT_W'(1);
    end else if (!xfer && rsp_valid) begin
      inflight_q <= inflight_q - CNT_W'(1);
    end
  end

  assign inflight = inflight_q;
  assign busy     = (inflight_q != '0);

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Self-checking bench for fpu_issue_arbiter: behavioural FPU, round-robin grant
// model and a due-cycle scoreboard checked by an independent monitor.
module tb_fpu_issue_arbiter;

  localparam int N   = 4;
  localparam int TW  = 4;
  localparam int LAT = 6;

  logic            CLK;
  logic            RST;
  logic            issue_en;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_op1;
  logic [N*32-1:0] req_op2;
  logic [N-1:0]    req_operation;
  logic [N*TW-1:0] req_tag;
  logic [31:0]     fpu_operand1;
  logic [31:0]     fpu_operand2;
  logic            fpu_operation;
  logic [31:0]     fpu_result;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [TW-1:0]   rsp_tag;
  logic [31:0]     rsp_result;
  logic [2:0]      inflight;
  logic            busy;

  fpu_issue_arbiter #(
    .N_REQ       (N),
    .TAG_W       (TW),
    .FPU_LATENCY (LAT),
    .DATA_W      (32)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .issue_en      (issue_en),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op1       (req_op1),
    .req_op2       (req_op2),
    .req_operation (req_operation),
    .req_tag       (req_tag),
    .fpu_operand1  (fpu_operand1),
    .fpu_operand2  (fpu_operand2),
    .fpu_operation (fpu_operation),
    .fpu_result    (fpu_result),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_tag       (rsp_tag),
    .rsp_result    (rsp_result),
    .inflight      (inflight),
    .busy          (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Integer-valued single-precision helpers (operands are small whole numbers).
  function automatic int f32_to_int(input logic [31:0] x);
    int e;
    int m;
    int v;
    e = int'(x[30:23]) - 127;
    if (x[30:23] == 8'd0 || e < 0 || e > 30) return 0;
    m = int'({1'b1, x[22:0]});
    v = (e <= 23) ? (m >>> (23 - e)) : (m <<< (e - 23));
    return x[31] ? -v : v;
  endfunction

  function automatic logic [31:0] int_to_f32(input int v);
    logic [31:0] m;
    logic [31:0] mant;
    int p;
    if (v == 0) return 32'd0;
    m = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    mant = (p <= 23) ? (m << (23 - p)) : (m >> (p - 23));
    return {(v < 0), 8'(127 + p), mant[22:0]};
  endfunction

  function automatic logic [31:0] fpu_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic op);
    int r;
    r = op ? (f32_to_int(a) - f32_to_int(b)) : (f32_to_int(a) + f32_to_int(b));
    return int_to_f32(r);
  endfunction

  // Behavioural FPU: LAT register ranks, no reset, no stall.
  logic [31:0] fpu_pipe [LAT];
  initial for (int k = 0; k < LAT; k++) fpu_pipe[k] = 32'd0;
  always @(posedge CLK) begin
    fpu_pipe[0] <= fpu_calc(fpu_operand1, fpu_operand2, fpu_operation);
    for (int k = 1; k < LAT; k++) fpu_pipe[k] <= fpu_pipe[k-1];
  end
  assign fpu_result = fpu_pipe[LAT-1];

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    logic [1:0]  id;
    logic [3:0]  tag;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  int   ptr   = N - 1;
  bit   armed = 0;

  // Monitor: samples at the falling edge, checks, then models the coming edge.
  always @(negedge CLK) begin
    logic [N-1:0] exp_rdy;
    int           g;
    bit           exp_v;
    exp_t         e;
    if (armed) begin
      chk("inflight", 72'(inflight), 72'(sb.size()));
      chk("busy", 72'(busy), 72'(sb.size() != 0));
      exp_v = (sb.size() != 0) && (sb[0].due == cyc);
      chk("rsp_valid", 72'(rsp_valid), 72'(exp_v));
      if (exp_v) begin
        e = sb.pop_front();
        if (rsp_valid) begin
          chk("rsp_id", 72'(rsp_id), 72'(e.id));
          chk("rsp_tag", 72'(rsp_tag), 72'(e.tag));
          chk("rsp_result", 72'(rsp_result), 72'(e.res));
        end
      end
      exp_rdy = '0;
      g = -1;
      if (!RST && issue_en) begin
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 72'(req_ready), 72'(exp_rdy));
      if (g >= 0) begin
        chk("fpu_drive", {7'd0, fpu_operand1, fpu_operand2, fpu_operation},
            {7'd0, req_op1[g*32 +: 32], req_op2[g*32 +: 32], req_operation[g]});
        e.due = cyc + LAT;
        e.id  = 2'(g);
        e.tag = req_tag[g*TW +: TW];
        e.res = fpu_calc(req_op1[g*32 +: 32], req_op2[g*32 +: 32], req_operation[g]);
        sb.push_back(e);
        ptr = g;
      end else begin
        chk("fpu_idle", {7'd0, fpu_operand1, fpu_operand2, fpu_operation}, 72'd0);
      end
    end
    if (RST) begin
      sb.delete();
      ptr   = N - 1;
      armed = 1;
    end
  end

  // ---------------- stimulus ----------------
  logic [N-1:0] took;

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [3:0] tag);
    req_op1[i*32 +: 32] = a;
    req_op2[i*32 +: 32] = b;
    req_operation[i]    = op;
    req_tag[i*TW +: TW] = tag;
    req_valid[i]        = 1'b1;
  endtask

  task automatic rand_req(input int i);
    int a;
    int b;
    a = int'($urandom_range(1000));
    b = int'($urandom_range(1000));
    if ($urandom_range(1) != 0) a = -a;
    if ($urandom_range(1) != 0) b = -b;
    set_req(i, int_to_f32(a), int_to_f32(b), 1'($urandom_range(1)), 4'($urandom_range(15)));
  endtask

  task automatic step();
    @(negedge CLK);
    took = req_valid & req_ready;
    @(posedge CLK);
    #1;
  endtask

  task automatic step_drop();
    step();
    req_valid = req_valid & ~took;
  endtask

  task automatic step_refill();
    step();
    for (int i = 0; i < N; i++) if (took[i]) rand_req(i);
  endtask

  initial begin
    RST           = 1'b1;
    issue_en      = 1'b1;
    req_valid     = '0;
    req_op1       = '0;
    req_op2       = '0;
    req_operation = '0;
    req_tag       = '0;
    repeat (3) step();
    RST = 1'b0;
    step();

    // Single requester 2: 1.0 + 2.0, tag 5.
    set_req(2, 32'h3F800000, 32'h40000000, 1'b0, 4'd5);
    step_drop();
    chk("first_grant_req2", 72'(took), 72'(4'b0100));
    repeat (10) step();

    // All four requesters continuously for eight transfers.
    for (int i = 0; i < N; i++) rand_req(i);
    repeat (8) step_refill();
    req_valid = '0;
    repeat (10) step();

    // issue_en gap right after a grant to requester 1.
    for (int i = 0; i < N; i++) rand_req(i);
    took = '0;
    for (int k = 0; k < 8 && !took[1]; k++) step_refill();
    chk("grant1_seen", 72'(took[1]), 72'd1);
    issue_en = 1'b0;
    repeat (3) step_refill();
    issue_en = 1'b1;
    step_refill();
    chk("resume_req2", 72'(took), 72'(4'b0100));
    repeat (3) step_refill();
    req_valid = '0;
    repeat (10) step();

    // Reset with four ops in flight; requester 0 must win afterwards.
    for (int i = 0; i < N; i++) rand_req(i);
    repeat (4) step_refill();
    RST = 1'b1;
    step();
    RST = 1'b0;
    step_refill();
    chk("post_reset_req0", 72'(took), 72'(4'b0001));
    req_valid = '0;
    repeat (10) step();

    // Steady state: one requester issuing every cycle.
    rand_req(0);
    repeat (24) step_refill();
    chk("steady_inflight", 72'(inflight), 72'(LAT));
    req_valid = '0;
    repeat (10) step();

    // Requester 3: 10.0 - 10.0, tag F.
    set_req(3, 32'h41200000, 32'h41200000, 1'b1, 4'hF);
    for (int k = 0; k < 4 && req_valid[3]; k++) step_drop();
    repeat (10) step();

    // Randomised traffic with occasional enable gaps and resets.
    repeat (400) begin
      issue_en = ($urandom_range(3) != 0);
      RST      = ($urandom_range(63) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(1) != 0) rand_req(i);
      end
      step_drop();
    end
    RST       = 1'b0;
    issue_en  = 1'b1;
    req_valid = '0;
    repeat (12) step();
    chk("drained", 72'(sb.size()), 72'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
